// File: rtl/ni_packetizer_if.sv
// Core-to-NI request/payload channel plus the NI-to-router flit channel (TX/RTS/DCTS).
// The master modport is the core/router environment; the slave modport is the packetizer.
interface ni_packetizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AXIS       = 4
);
    logic [AXIS-1:0]       cur_addr;
    logic                  req_valid;
    logic                  req_ready;
    logic [AXIS-1:0]       req_dst;
    logic [11:0]           req_len;
    logic                  data_valid;
    logic                  data_ready;
    logic [27:0]           data_in;
    logic [DATA_WIDTH-1:0] TX;
    logic                  RTS;
    logic                  DCTS;
    logic                  len_err;
    logic [7:0]            pkt_id;

    modport master (
        output cur_addr, req_valid, req_dst, req_len, data_valid, data_in, DCTS,
        input  req_ready, data_ready, TX, RTS, len_err, pkt_id
    );

    modport slave (
        input  cur_addr, req_valid, req_dst, req_len, data_valid, data_in, DCTS,
        output req_ready, data_ready, TX, RTS, len_err, pkt_id
    );
endinterface

// File: rtl/ni_packetizer.sv
// Local NI transmit stage: turns core requests into header/body/tail flits for the router Local port.
// Define NI_PARITY_EN to put even parity over the whole flit into bit [0]; otherwise bit [0] is 0.
module ni_packetizer #(
    parameter int DATA_WIDTH  = 32,
    parameter int AXIS        = 4,
    parameter int MAX_PAYLOAD = 16
) (
    input  logic           clk,
    input  logic           rst,
    ni_packetizer_if.slave bus
);
    localparam logic [11:0] MAX_LEN     = 12'(MAX_PAYLOAD);
    localparam logic [2:0]  TYPE_HEADER = 3'b001;
    localparam logic [2:0]  TYPE_BODY   = 3'b010;
    localparam logic [2:0]  TYPE_TAIL   = 3'b100;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t                state_reg;
    logic [AXIS-1:0]       dst_reg;
    logic [11:0]           len_reg;
    logic [11:0]           remaining_reg;
    logic [DATA_WIDTH-1:0] tx_reg;
    logic                  rts_reg;
    logic                  len_err_reg;
    logic [7:0]            pkt_id_reg;

    logic                  launch_ok;
    logic                  req_fire;
    logic                  len_legal;
    logic                  data_fire;
    logic [DATA_WIDTH-1:1] header_body;
    logic [DATA_WIDTH-1:1] payload_body;

`ifdef NI_PARITY_EN
    function automatic logic [DATA_WIDTH-1:0] seal(input logic [DATA_WIDTH-1:1] body);
        return {body, ^body};
    endfunction
`else
    function automatic logic [DATA_WIDTH-1:0] seal(input logic [DATA_WIDTH-1:1] body);
        return {body, 1'b0};
    endfunction
`endif

    // A flit may only launch when the previous one is not being strobed, so the
    // router's full flag from the last write is visible before the next one.
    assign launch_ok = bus.DCTS && !rts_reg;
    assign req_fire  = bus.req_valid && (state_reg == IDLE);
    assign len_legal = (bus.req_len != 12'd0) && (bus.req_len <= MAX_LEN);
    assign data_fire = (state_reg == PAYLOAD) && launch_ok && bus.data_valid;

    assign header_body  = {TYPE_HEADER, len_reg + 12'd1, dst_reg, bus.cur_addr, pkt_id_reg};
    assign payload_body = {(remaining_reg == 12'd1) ? TYPE_TAIL : TYPE_BODY, bus.data_in};

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.data_ready = (state_reg == PAYLOAD) && launch_ok;
    assign bus.TX         = tx_reg;
    assign bus.RTS        = rts_reg;
    assign bus.len_err    = len_err_reg;
    assign bus.pkt_id     = pkt_id_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            dst_reg       <= '0;
            len_reg       <= '0;
            remaining_reg <= '0;
            tx_reg        <= '0;
            rts_reg       <= 1'b0;
            len_err_reg   <= 1'b0;
            pkt_id_reg    <= '0;
        end else begin
            rts_reg     <= 1'b0;
            len_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_fire) begin
                        if (len_legal) begin
                            dst_reg   <= bus.req_dst;
                            len_reg   <= bus.req_len;
                            state_reg <= HEADER;
                        end else begin
                            len_err_reg <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (launch_ok) begin
                        tx_reg        <= seal(header_body);
                        rts_reg       <= 1'b1;
                        pkt_id_reg    <= pkt_id_reg + 8'd1;
                        remaining_reg <= len_reg;
                        state_reg     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (data_fire) begin
                        tx_reg        <= seal(payload_body);
                        rts_reg       <= 1'b1;
                        remaining_reg <= remaining_reg - 12'd1;
                        if (remaining_reg == 12'd1) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ni_packetizer.sv
// Scoreboard bench for ni_packetizer: stimulus pushes expected flits, a negedge monitor pops and compares.
module tb_ni_packetizer;
    localparam int MAX_PAYLOAD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ni_packetizer_if #(.DATA_WIDTH(32), .AXIS(4)) bus ();

    ni_packetizer #(.DATA_WIDTH(32), .AXIS(4), .MAX_PAYLOAD(MAX_PAYLOAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          flit_cycles[$];
    int          cyc = 0;
    int          flits_seen = 0;
    int          model_id = 0;
    int          acc_cycle = 0;
    int          dcts_mode = 1;   // 0 low, 1 high, 2 random
    logic        rts_prev = 1'b0;
    logic        dcts_prev = 1'b0;

    function automatic logic [31:0] seal(input logic [31:1] b);
`ifdef NI_PARITY_EN
        return {b, ^b};
`else
        return {b, 1'b0};
`endif
    endfunction

    function automatic logic [31:0] hdr_flit(input int dst, input int src, input int len, input int id);
        logic [31:1] b;
        b = {3'b001, 12'(len + 1), 4'(dst), 4'(src), 8'(id)};
        return seal(b);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {bus.TX, bus.RTS, bus.len_err, bus.pkt_id, bus.req_ready, bus.data_ready},
            {32'h0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    endtask

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // DCTS driver: only this process touches DCTS
    initial begin
        bus.DCTS = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (dcts_mode)
                0:       bus.DCTS = 1'b0;
                1:       bus.DCTS = 1'b1;
                default: bus.DCTS = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: every strobed flit must obey the launch rule and match the queue head
    initial forever begin
        @(negedge clk);
        if (rst) begin
            rts_prev  = 1'b0;
            dcts_prev = bus.DCTS;
        end else begin
            if (bus.RTS) begin
                chk("launch_rule", {dcts_prev, rts_prev}, 2'b10);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit actual=%08h required=none", bus.TX);
                end else begin
                    chk("flit", bus.TX, exp_q.pop_front());
                end
                flit_cycles.push_back(cyc);
                flits_seen++;
            end
            rts_prev  = bus.RTS;
            dcts_prev = bus.DCTS;
        end
    end

    task automatic send(input int dst, input int len, input int max_gap, input int gap2_at,
                        input int abort_after);
        logic [27:0] words[$];
        bit fire;
        int budget;
        bit legal;
        legal = (len >= 1) && (len <= MAX_PAYLOAD);
        for (int i = 0; i < len && legal; i++) words.push_back(28'($urandom));
        bus.req_valid = 1'b1;
        bus.req_dst   = 4'(dst);
        bus.req_len   = 12'(len);
        fire   = 1'b0;
        budget = 200;
        while (!fire && budget > 0) begin
            @(negedge clk);
            fire      = bus.req_ready;
            acc_cycle = cyc;
            @(posedge clk);
            #1;
            budget--;
        end
        bus.req_valid = 1'b0;
        if (!fire) begin
            checks++;
            errors++;
            $display("FAIL req_accept actual=timeout required=accepted");
            return;
        end
        if (!legal) begin
            @(negedge clk);
            chk("len_err_pulse", bus.len_err, 1);
            chk("illegal_no_rts", bus.RTS, 0);
            @(negedge clk);
            chk("len_err_clear", bus.len_err, 0);
            chk("illegal_pkt_id", bus.pkt_id, 64'(model_id));
            @(posedge clk);
            #1;
            return;
        end
        exp_q.push_back(hdr_flit(dst, int'(bus.cur_addr), len, model_id));
        model_id = (model_id + 1) % 256;
        for (int i = 0; i < len; i++)
            exp_q.push_back(seal({(i == len - 1) ? 3'b100 : 3'b010, words[i]}));
        for (int i = 0; i < len; i++) begin
            bus.data_in = words[i];
            repeat ((i == gap2_at) ? 2 : $urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            bus.data_valid = 1'b1;
            fire   = 1'b0;
            budget = 200;
            while (!fire && budget > 0) begin
                @(negedge clk);
                fire = bus.data_ready;
                @(posedge clk);
                #1;
                budget--;
            end
            bus.data_valid = 1'b0;
            if (!fire) begin
                checks++;
                errors++;
                $display("FAIL data_accept actual=timeout required=accepted word=%0d", i);
                return;
            end
            if (abort_after == i + 1) return;
        end
        budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        chk("drain", 64'(exp_q.size()), 0);
        @(negedge clk);
        chk("pkt_id_after", bus.pkt_id, 64'(model_id));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        bus.cur_addr   = 4'd0;
        bus.req_valid  = 1'b0;
        bus.req_dst    = 4'd0;
        bus.req_len    = 12'd0;
        bus.data_valid = 1'b0;
        bus.data_in    = 28'd0;

        // Reset with inputs toggling
        dcts_mode = 2;
        repeat (6) begin
            @(posedge clk);
            #1;
            bus.req_valid  = 1'($urandom);
            bus.req_len    = 12'($urandom_range(0, 20));
            bus.data_valid = 1'($urandom);
            bus.data_in    = 28'($urandom);
            @(negedge clk);
            chk_reset_outputs("reset_hold");
        end
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.data_valid = 1'b0;
        dcts_mode      = 1;
        rst            = 1'b0;
        @(negedge clk);
        chk("reset_release_req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;

        // Single-payload packet and latency
        flit_cycles.delete();
        send(3, 1, 0, -1, 0);
        chk("single_flit_count", 64'(flit_cycles.size()), 2);
        if (flit_cycles.size() == 2) begin
            chk("header_latency", 64'(flit_cycles[0] - acc_cycle), 2);
            chk("payload_latency", 64'(flit_cycles[1] - acc_cycle), 4);
        end

        // Backpressure: DCTS low after the header, data_valid gap mid-packet
        base = flits_seen;
        fork
            send(5, 3, 0, 1, 0);
            begin
                int budget;
                budget = 100;
                while (flits_seen == base && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
                @(posedge clk);
                #1;
                dcts_mode = 0;
                repeat (5) @(posedge clk);
                #1;
                dcts_mode = 1;
            end
        join
        chk("backpressure_flits", 64'(flits_seen - base), 4);

        // Illegal lengths
        send(2, 0, 0, -1, 0);
        send(2, MAX_PAYLOAD + 1, 0, -1, 0);

        // Reset after the second body flit of a 4-payload packet
        send(6, 4, 0, -1, 2);
        @(negedge clk);
        #1;
        chk("abort_pending", 64'(exp_q.size()), 2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("reset_mid_packet");
        exp_q.delete();
        model_id = 0;
        bus.cur_addr = 4'd5;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // pkt_id wrap: headers 0..255 then 0
        for (int n = 0; n < 257; n++) send(n % 16, 1, 0, -1, 0);
        chk("wrap_pkt_id", bus.pkt_id, 64'(1));

        // Randomized traffic
        dcts_mode = 2;
        for (int n = 0; n < 40; n++)
            send($urandom_range(0, 15), $urandom_range(0, MAX_PAYLOAD + 1), 2, -1, 0);
        dcts_mode = 1;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
